stack_cpu_core: RTL and testbench

//  Parametrised successor stack CPU: fetch/decode/execute over a 16-bit instruction stream.

---
 rtl/stack_cpu_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_stack_cpu_core.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_core.sv
// stack_cpu_core: stack CPU fed by a 16-bit instruction stream. It has a data
// stack, a return stack (CALL/RET), a conditional branch, an ALU and a
// valid/ready output port.
// Instruction fetch may insert wait states: imem_req stays high until imem_ack.
// Optional macro STACK_CHECK_EN: stack overflow/underflow stops the core in
// FAULT with fault_code set. Without it the stack pointers wrap.
// Handshake: out_data is a beat when out_valid && out_ready at a rising clk;
// out_valid and out_data hold steady until that beat is taken.
module stack_cpu_core #(
    parameter int DATA_W       = 16,
    parameter int DSTACK_DEPTH = 16,
    parameter int RSTACK_DEPTH = 8,
    parameter int ADDR_W       = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            imem_req,
    output logic [ADDR_W-1:0]               imem_addr,
    input  logic [15:0]                     imem_rdata,
    input  logic                            imem_ack,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            halted,
    output logic                            fault,
    output logic [1:0]                      fault_code,
    output logic [2:0]                      dbg_state,
    output logic [ADDR_W:0]                 dbg_ip,
    output logic [$clog2(DSTACK_DEPTH):0]   dbg_dsp,
    output logic [$clog2(RSTACK_DEPTH):0]   dbg_rsp
);
    localparam int DP   = $clog2(DSTACK_DEPTH);
    localparam int RP   = $clog2(RSTACK_DEPTH);
    localparam int IP_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_FETCH, S_EXEC_W, S_EXEC_HI, S_EXEC_LO, S_OUT_WAIT, S_HALT, S_FAULT
    } state_t;

    state_t              state, state_n;
    logic [IP_W-1:0]     ip, ip_n;
    logic [15:0]         ir, ir_n;
    logic [DP:0]         dsp, dsp_n;
    logic [RP:0]         rsp, rsp_n;
    logic [DATA_W-1:0]   dstk [DSTACK_DEPTH];
    logic [IP_W-1:0]     rstk [RSTACK_DEPTH];
    logic [DATA_W-1:0]   out_q, out_n;
    logic                resume_lo, resume_lo_n;
    logic [1:0]          fc_q, fc_n;

    logic [DP-1:0]       p_idx, t_idx, n_idx;
    logic [RP-1:0]       rp_idx, rt_idx;
    logic [DATA_W-1:0]   tos, nos, alu;
    logic [7:0]          bop;
    logic [IP_W-1:0]     jmp_tgt, rtop;

    logic [1:0]          need;
    logic                d_inc, d_dec, r_push, r_pop;
    logic                we0, we1;
    logic [DP-1:0]       wa0, wa1;
    logic [DATA_W-1:0]   wd0, wd1;
`ifdef STACK_CHECK_EN
    logic [1:0]          fault_hit;
`else
    logic                unused_need;
    assign unused_need = ^need;
`endif

    // Operand fetch from the stacks, byte-op select, branch target and ALU result
    always_comb begin
        p_idx   = dsp[DP-1:0];
        t_idx   = dsp[DP-1:0] - DP'(1);
        n_idx   = dsp[DP-1:0] - DP'(2);
        rp_idx  = rsp[RP-1:0];
        rt_idx  = rsp[RP-1:0] - RP'(1);
        tos     = dstk[t_idx];
        nos     = dstk[n_idx];
        rtop    = rstk[rt_idx];
        bop     = (state == S_EXEC_HI) ? ir[15:8] : ir[7:0];
        jmp_tgt = (ip + IP_W'(2) + {{(IP_W-13){ir[12]}}, ir[12:0]}) & ~IP_W'(1);
        case (bop)
            8'h01:   alu = nos + tos;
            8'h02:   alu = nos - tos;
            8'h08:   alu = nos & tos;
            8'h09:   alu = nos | tos;
            8'h0A:   alu = nos ^ tos;
            default: alu = '0;
        endcase
    end

    // Next state and datapath control; a stack violation (when checked) cancels every update
    always_comb begin
        state_n     = state;
        ip_n        = ip;
        ir_n        = ir;
        out_n       = out_q;
        resume_lo_n = resume_lo;
        fc_n        = fc_q;
        need        = 2'd0;
        d_inc       = 1'b0;
        d_dec       = 1'b0;
        r_push      = 1'b0;
        r_pop       = 1'b0;
        we0         = 1'b0;
        we1         = 1'b0;
        wa0         = p_idx;
        wa1         = p_idx;
        wd0         = tos;
        wd1         = tos;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_n = imem_rdata;
                    if (!ip[0] && imem_rdata[15:13] != 3'b000) state_n = S_EXEC_W;
                    else if (!ip[0])                           state_n = S_EXEC_HI;
                    else                                       state_n = S_EXEC_LO;
                end
            end
            S_EXEC_W: begin
                ip_n    = ip + IP_W'(2);
                state_n = S_FETCH;
                if (ir[15]) begin
                    d_inc = 1'b1;
                    we0   = 1'b1;
                    wd0   = DATA_W'(ir[14:0]);
                end else begin
                    case (ir[14:13])
                        2'b01: ip_n = jmp_tgt;
                        2'b10: begin r_push = 1'b1; ip_n = jmp_tgt; end
                        2'b11: begin
                            need  = 2'd1;
                            d_dec = 1'b1;
                            if (tos == '0) ip_n = jmp_tgt;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC_HI, S_EXEC_LO: begin
                ip_n    = ip + IP_W'(1);
                state_n = (state == S_EXEC_HI) ? S_EXEC_LO : S_FETCH;
                case (bop)
                    8'h01, 8'h02, 8'h08, 8'h09, 8'h0A: begin
                        need = 2'd2; d_dec = 1'b1; we0 = 1'b1; wa0 = n_idx; wd0 = alu;
                    end
                    8'h03: begin need = 2'd1; d_inc = 1'b1; we0 = 1'b1; end
                    8'h04: begin
                        need = 2'd2;
                        we0 = 1'b1; wa0 = t_idx; wd0 = nos;
                        we1 = 1'b1; wa1 = n_idx; wd1 = tos;
                    end
                    8'h05: begin need = 2'd1; d_dec = 1'b1; end
                    8'h06: begin
                        need        = 2'd1;
                        d_dec       = 1'b1;
                        out_n       = tos;
                        resume_lo_n = (state == S_EXEC_HI);
                        state_n     = S_OUT_WAIT;
                    end
                    8'h07: begin r_pop = 1'b1; ip_n = rtop & ~IP_W'(1); state_n = S_FETCH; end
                    8'h0B: begin need = 2'd2; d_inc = 1'b1; we0 = 1'b1; wd0 = nos; end
                    8'hFF: state_n = S_HALT;
                    default: ;
                endcase
            end
            S_OUT_WAIT: begin
                if (out_ready) state_n = resume_lo ? S_EXEC_LO : S_FETCH;
            end
            default: ;
        endcase
        dsp_n = dsp + (DP+1)'(d_inc) - (DP+1)'(d_dec);
        rsp_n = rsp + (RP+1)'(r_push) - (RP+1)'(r_pop);
`ifdef STACK_CHECK_EN
        fault_hit = 2'd0;
        if ((DP+1)'(need) > dsp)                                  fault_hit = 2'd2;
        else if (d_inc && dsp == (DP+1)'(DSTACK_DEPTH))           fault_hit = 2'd1;
        else if ((r_push && rsp == (RP+1)'(RSTACK_DEPTH)) ||
                 (r_pop && rsp == '0))                            fault_hit = 2'd3;
        if (fault_hit != 2'd0) begin
            state_n = S_FAULT;
            ip_n    = ip;
            dsp_n   = dsp;
            rsp_n   = rsp;
            out_n   = out_q;
            we0     = 1'b0;
            we1     = 1'b0;
            r_push  = 1'b0;
            fc_n    = fault_hit;
        end
`else
        dsp_n[DP] = 1'b0;
        rsp_n[RP] = 1'b0;
`endif
    end

    // State register and architectural registers; reset abandons any fetch or OUT beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ip        <= '0;
            ir        <= '0;
            dsp       <= '0;
            rsp       <= '0;
            out_q     <= '0;
            resume_lo <= 1'b0;
            fc_q      <= 2'd0;
        end else begin
            state     <= state_n;
            ip        <= ip_n;
            ir        <= ir_n;
            dsp       <= dsp_n;
            rsp       <= rsp_n;
            out_q     <= out_n;
            resume_lo <= resume_lo_n;
            fc_q      <= fc_n;
        end
    end

    // Stack storage writes (SWAP uses both data-stack write ports)
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we0)    dstk[wa0]    <= wd0;
            if (we1)    dstk[wa1]    <= wd1;
            if (r_push) rstk[rp_idx] <= ip + IP_W'(2);
        end
    end

    // Outputs decoded from state; imem_req is held low while rst is asserted
    always_comb begin
        imem_req   = (state == S_FETCH) && !rst;
        imem_addr  = ip[ADDR_W:1];
        out_valid  = (state == S_OUT_WAIT);
        out_data   = out_q;
        halted     = (state == S_HALT);
        fault      = (state == S_FAULT);
        fault_code = fc_q;
        dbg_state  = state;
        dbg_ip     = ip;
        dbg_dsp    = dsp;
        dbg_rsp    = rsp;
    end
endmodule

// File: tb/tb_stack_cpu_core.sv
`timescale 1ns/1ps
// Bench for stack_cpu_core: a wait-state instruction memory, an OUT-beat
// scoreboard and one task per scenario.
module tb_stack_cpu_core;
  localparam int DATA_W = 16;
  localparam int DDEPTH = 16;
  localparam int RDEPTH = 8;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata = '0;
  logic              imem_ack = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              halted, fault;
  logic [1:0]        fault_code;
  logic [2:0]        dbg_state;
  logic [ADDR_W:0]   dbg_ip;
  logic [4:0]        dbg_dsp;
  logic [3:0]        dbg_rsp;

  logic [15:0]       imem [64];
  int                ack_delay = 0;
  int                wait_cnt = 0;
  int                total = 0;
  int                bad = 0;
  int                beat_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              prev_valid = 1'b0;
  logic              prev_hs = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  stack_cpu_core #(
    .DATA_W(DATA_W), .DSTACK_DEPTH(DDEPTH), .RSTACK_DEPTH(RDEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .fault(fault), .fault_code(fault_code),
    .dbg_state(dbg_state), .dbg_ip(dbg_ip), .dbg_dsp(dbg_dsp), .dbg_rsp(dbg_rsp)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // instruction memory: acks after ack_delay waiting cycles, driven on negedge
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt == ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = imem[int'(imem_addr[5:0])];
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // scoreboard: pop expected beat on handshake, and check out_data holds while stalled
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_v;
    if (!rst && prev_valid && !prev_hs && out_valid) begin
      total++;
      if (out_data !== prev_data) begin
        bad++;
        $display("FAIL out_data_stable got=%0h want=%0h", out_data, prev_data);
      end
    end
    if (!rst && out_valid && out_ready) begin
      beat_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got=%0h want=none", out_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (out_data !== exp_v) begin
          bad++;
          $display("FAIL out_beat got=%0h want=%0h", out_data, exp_v);
        end
      end
    end
    prev_valid = out_valid;
    prev_hs    = out_valid && out_ready;
    prev_data  = out_data;
  end

  function automatic logic [15:0] op_push(input logic [14:0] v);
    return {1'b1, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 16'h00FF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    beat_cnt = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic run_until_stop(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (halted || fault) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (halted || fault) ok = 1'b1;
  endtask

  task automatic test_reset();
    clear_prog();
    rst = 1'b1;
    tick();
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_imem_req got=%0b want=0", imem_req); end
    total++; if (imem_addr !== '0) begin bad++; $display("FAIL rst_imem_addr got=%0h want=0", imem_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%0h want=0", out_data); end
    total++; if (halted !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b want=00", halted, fault); end
    total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL rst_fault_code got=%0d want=0", fault_code); end
    total++; if (dbg_ip !== '0 || dbg_dsp !== '0 || dbg_rsp !== '0) begin bad++; $display("FAIL rst_ptrs got=%0h/%0h/%0h want=0/0/0", dbg_ip, dbg_dsp, dbg_rsp); end
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_release_req got=%0b want=1", imem_req); end
  endtask

  task automatic test_add_out();
    bit ok;
    clear_prog();
    imem[0] = op_push(15'd5); imem[1] = op_push(15'd7); imem[2] = 16'h0106; imem[3] = 16'h00FF;
    out_ready = 1'b1; ack_delay = 0;
    do_reset();
    exp_q.push_back(16'd12);
    run_until_stop(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL add_out_stop got=running want=halted"); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL add_out_halted got=%0b want=1", halted); end
    total++; if (beat_cnt != 1 || exp_q.size() != 0) begin bad++; $display("FAIL add_out_beats got=%0d want=1", beat_cnt); end
    total++; if (dbg_ip !== 16'd8) begin bad++; $display("FAIL add_out_ip got=%0d want=8", dbg_ip); end
    total++; if (dbg_dsp !== 5'd0) begin bad++; $display("FAIL add_out_dsp got=%0d want=0", dbg_dsp); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_no_fetch got=%0b want=0", imem_req); end
  endtask

  task automatic test_out_backpressure();
    bit ok;
    clear_prog();
    imem[0] = op_push(15'd5); imem[1] = op_push(15'd7); imem[2] = 16'h0106; imem[3] = 16'h00FF;
    out_ready = 1'b0; ack_delay = 0;
    do_reset();
    exp_q.push_back(16'd12);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_valid_seen got=0 want=1"); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held got=%0b want=1", out_valid); end
      total++; if (out_data !== 16'd12) begin bad++; $display("FAIL bp_data got=%0h want=c", out_data); end
      total++; if (dbg_ip !== 16'd6) begin bad++; $display("FAIL bp_ip_frozen got=%0d want=6", dbg_ip); end
    end
    total++; if (beat_cnt != 0) begin bad++; $display("FAIL bp_no_beat got=%0d want=0", beat_cnt); end
    out_ready = 1'b1;
    run_until_stop(200, ok);
    total++; if (!ok || halted !== 1'b1) begin bad++; $display("FAIL bp_halted got=%0b want=1", halted); end
    total++; if (beat_cnt != 1 || exp_q.size() != 0) begin bad++; $display("FAIL bp_beats got=%0d want=1", beat_cnt); end
  endtask

  task automatic test_call_ret();
    bit ok;
    clear_prog();
    imem[0] = 16'h4006; imem[1] = 16'h00FF; imem[4] = op_push(15'd9); imem[5] = 16'h0607;
    out_ready = 1'b1; ack_delay = 0;
    do_reset();
    exp_q.push_back(16'd9);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dbg_ip == 16'd8) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL call_target got=%0d want=8", dbg_ip); end
    total++; if (dbg_rsp !== 4'd1) begin bad++; $display("FAIL call_rsp got=%0d want=1", dbg_rsp); end
    run_until_stop(200, ok);
    total++; if (!ok || halted !== 1'b1) begin bad++; $display("FAIL call_halted got=%0b want=1", halted); end
    total++; if (dbg_ip !== 16'd4) begin bad++; $display("FAIL ret_ip got=%0d want=4", dbg_ip); end
    total++; if (dbg_rsp !== 4'd0 || dbg_dsp !== 5'd0) begin bad++; $display("FAIL ret_ptrs got=%0d/%0d want=0/0", dbg_rsp, dbg_dsp); end
    total++; if (beat_cnt != 1 || exp_q.size() != 0) begin bad++; $display("FAIL call_beats got=%0d want=1", beat_cnt); end
  endtask

  task automatic test_jz();
    bit ok;
    logic [15:0] exp_ip;
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      imem[0] = (t == 0) ? op_push(15'd0) : op_push(15'd1);
      imem[1] = 16'h6004; imem[2] = op_push(15'h44); imem[3] = 16'h06FF;
      imem[4] = op_push(15'h33); imem[5] = 16'h06FF;
      out_ready = 1'b1; ack_delay = 0;
      do_reset();
      exp_q.push_back((t == 0) ? 16'h33 : 16'h44);
      exp_ip = (t == 0) ? 16'd12 : 16'd8;
      run_until_stop(200, ok);
      total++; if (!ok || halted !== 1'b1) begin bad++; $display("FAIL jz_halted case=%0d got=%0b want=1", t, halted); end
      total++; if (dbg_ip !== exp_ip) begin bad++; $display("FAIL jz_ip case=%0d got=%0d want=%0d", t, dbg_ip, exp_ip); end
      total++; if (dbg_dsp !== 5'd0) begin bad++; $display("FAIL jz_dsp case=%0d got=%0d want=0", t, dbg_dsp); end
      total++; if (beat_cnt != 1 || exp_q.size() != 0) begin bad++; $display("FAIL jz_beats case=%0d got=%0d want=1", t, beat_cnt); end
    end
  endtask

  task automatic test_alu_ops();
    bit ok;
    logic [DATA_W-1:0] a, b;
    for (int t = 0; t < 3; t++) begin
      a = DATA_W'($urandom_range(0, 32767));
      b = DATA_W'($urandom_range(0, 32767));
      clear_prog();
      imem[0] = op_push(a[14:0]); imem[1] = op_push(b[14:0]);
      imem[2] = 16'h0B0B; imem[3] = 16'h0206;
      imem[4] = 16'h0B0B; imem[5] = 16'h0806;
      imem[6] = 16'h0B0B; imem[7] = 16'h0906;
      imem[8] = 16'h0B0B; imem[9] = 16'h0A06;
      imem[10] = 16'h0406; imem[11] = 16'h0301;
      imem[12] = 16'h0305; imem[13] = 16'h06FF;
      out_ready = 1'b1; ack_delay = $urandom_range(0, 2);
      do_reset();
      exp_q.push_back(a - b);
      exp_q.push_back(a & b);
      exp_q.push_back(a | b);
      exp_q.push_back(a ^ b);
      exp_q.push_back(a);
      exp_q.push_back(b + b);
      run_until_stop(2000, ok);
      total++; if (!ok || halted !== 1'b1) begin bad++; $display("FAIL alu_halted case=%0d got=%0b want=1", t, halted); end
      total++; if (beat_cnt != 6 || exp_q.size() != 0) begin bad++; $display("FAIL alu_beats case=%0d got=%0d want=6", t, beat_cnt); end
      total++; if (dbg_dsp !== 5'd0) begin bad++; $display("FAIL alu_dsp case=%0d got=%0d want=0", t, dbg_dsp); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_prog();
    for (int i = 0; i <= DDEPTH; i++) imem[i] = op_push(15'(i + 1));
    imem[DDEPTH+1] = 16'h00FF;
    out_ready = 1'b1; ack_delay = 0;
    do_reset();
    run_until_stop(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_stop got=running want=stopped"); end
`ifdef STACK_CHECK_EN
    total++; if (fault !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL ovf_fault got=%0b want=1", fault); end
    total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL ovf_code got=%0d want=1", fault_code); end
    total++; if (dbg_dsp !== 5'(DDEPTH)) begin bad++; $display("FAIL ovf_dsp got=%0d want=%0d", dbg_dsp, DDEPTH); end
    total++; if (dbg_ip !== 16'(2 * DDEPTH)) begin bad++; $display("FAIL ovf_ip got=%0d want=%0d", dbg_ip, 2 * DDEPTH); end
`else
    total++; if (fault !== 1'b0 || fault_code !== 2'd0) begin bad++; $display("FAIL wrap_no_fault got=%0b/%0d want=0/0", fault, fault_code); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL wrap_halted got=%0b want=1", halted); end
    total++; if (dbg_dsp !== 5'd1) begin bad++; $display("FAIL wrap_dsp got=%0d want=1", dbg_dsp); end
    total++; if (dbg_ip !== 16'(2 * DDEPTH + 4)) begin bad++; $display("FAIL wrap_ip got=%0d want=%0d", dbg_ip, 2 * DDEPTH + 4); end
`endif
  endtask

`ifdef STACK_CHECK_EN
  task automatic test_underflow();
    bit ok;
    logic [1:0]  exp_code;
    logic [15:0] exp_ip;
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      imem[0] = (t == 0) ? 16'h0006 : 16'h0700;
      exp_code = (t == 0) ? 2'd2 : 2'd3;
      exp_ip   = (t == 0) ? 16'd1 : 16'd0;
      out_ready = 1'b1; ack_delay = 0;
      do_reset();
      run_until_stop(200, ok);
      total++; if (!ok || fault !== 1'b1) begin bad++; $display("FAIL udf_fault case=%0d got=%0b want=1", t, fault); end
      total++; if (fault_code !== exp_code) begin bad++; $display("FAIL udf_code case=%0d got=%0d want=%0d", t, fault_code, exp_code); end
      total++; if (dbg_ip !== exp_ip) begin bad++; $display("FAIL udf_ip case=%0d got=%0d want=%0d", t, dbg_ip, exp_ip); end
      total++; if (dbg_dsp !== 5'd0 || dbg_rsp !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL udf_state case=%0d got=%0d/%0d/%0b want=0/0/0", t, dbg_dsp, dbg_rsp, out_valid); end
    end
  endtask
`endif

  task automatic test_wait_and_reset();
    bit ok;
    clear_prog();
    imem[0] = op_push(15'd5); imem[1] = op_push(15'd7); imem[2] = 16'h0106; imem[3] = 16'h00FF;
    out_ready = 1'b0; ack_delay = 4;
    do_reset();
    exp_q.push_back(16'd12);
    for (int i = 0; i < 5; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== '0 || dbg_state !== 3'd0) begin bad++; $display("FAIL wait_req_held cyc=%0d got=%0b/%0h want=1/0", i, imem_req, imem_addr); end
      tick();
    end
    total++; if (dbg_state === 3'd0) begin bad++; $display("FAIL wait_ack_taken got=%0d want=exec", dbg_state); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL wait_valid_seen got=0 want=1"); end
    rst = 1'b1;
    exp_q.delete();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_wait_valid got=%0b want=0", out_valid); end
    total++; if (dbg_ip !== '0) begin bad++; $display("FAIL rst_out_wait_ip got=%0d want=0", dbg_ip); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_out_wait_req got=%0b want=0", imem_req); end
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== '0) begin bad++; $display("FAIL rst_drop_req got=%0b/%0h want=1/0", imem_req, imem_addr); end
    beat_cnt = 0;
    exp_q.push_back(16'd12);
    out_ready = 1'b1;
    run_until_stop(500, ok);
    total++; if (!ok || halted !== 1'b1) begin bad++; $display("FAIL wait_rerun_halted got=%0b want=1", halted); end
    total++; if (beat_cnt != 1 || exp_q.size() != 0) begin bad++; $display("FAIL wait_rerun_beats got=%0d want=1", beat_cnt); end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_add_out();
    test_out_backpressure();
    test_call_ret();
    test_jz();
    test_alu_ops();
    test_overflow();
`ifdef STACK_CHECK_EN
    test_underflow();
`endif
    test_wait_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
